// File: rtl/vga_pkg.sv
// Shared constants for the VGA colour-processor stage.
//   - resolution codes accepted on the resolution input
//   - active width/height for each supported resolution
//   - RGB888 / RGB444 data widths
package vga_pkg;

    localparam int RGB888_W = 24;
    localparam int RGB444_W = 12;
    localparam int ACT_W    = 11;

    localparam logic [3:0] RES_640x480   = 4'b0000;
    localparam logic [3:0] RES_800x600   = 4'b0001;
    localparam logic [3:0] RES_1024x768  = 4'b0010;
    localparam logic [3:0] RES_1280x720  = 4'b0011;
    localparam logic [3:0] RES_1280x1024 = 4'b0100;
    localparam logic [3:0] RES_1280x800  = 4'b0101;
    localparam logic [3:0] RES_1440x900  = 4'b0110;
    localparam logic [3:0] RES_1600x900  = 4'b0111;
    localparam logic [3:0] RES_1680x1050 = 4'b1000;
    localparam logic [3:0] RES_1920x1080 = 4'b1001;

    localparam logic [ACT_W-1:0] H_640   = 11'd640;
    localparam logic [ACT_W-1:0] H_800   = 11'd800;
    localparam logic [ACT_W-1:0] H_1024  = 11'd1024;
    localparam logic [ACT_W-1:0] H_1280  = 11'd1280;
    localparam logic [ACT_W-1:0] H_1440  = 11'd1440;
    localparam logic [ACT_W-1:0] H_1600  = 11'd1600;
    localparam logic [ACT_W-1:0] H_1680  = 11'd1680;
    localparam logic [ACT_W-1:0] H_1920  = 11'd1920;

    localparam logic [ACT_W-1:0] V_480   = 11'd480;
    localparam logic [ACT_W-1:0] V_600   = 11'd600;
    localparam logic [ACT_W-1:0] V_720   = 11'd720;
    localparam logic [ACT_W-1:0] V_768   = 11'd768;
    localparam logic [ACT_W-1:0] V_800   = 11'd800;
    localparam logic [ACT_W-1:0] V_900   = 11'd900;
    localparam logic [ACT_W-1:0] V_1024  = 11'd1024;
    localparam logic [ACT_W-1:0] V_1050  = 11'd1050;
    localparam logic [ACT_W-1:0] V_1080  = 11'd1080;

endpackage

// File: rtl/vga_res_lut.sv
// Resolution decoder: maps a 4-bit resolution code to the active
// width/height. Unused codes fall back to 640x480.
//   resolution  in   4   resolution code
//   h_act       out  11  active columns
//   v_act       out  11  active rows
module vga_res_lut
    import vga_pkg::*;
(
    input  logic [3:0]       resolution,
    output logic [ACT_W-1:0] h_act,
    output logic [ACT_W-1:0] v_act
);

    always_comb begin
        h_act = H_640;
        v_act = V_480;
        case (resolution)
            RES_640x480:   begin h_act = H_640;  v_act = V_480;  end
            RES_800x600:   begin h_act = H_800;  v_act = V_600;  end
            RES_1024x768:  begin h_act = H_1024; v_act = V_768;  end
            RES_1280x720:  begin h_act = H_1280; v_act = V_720;  end
            RES_1280x1024: begin h_act = H_1280; v_act = V_1024; end
            RES_1280x800:  begin h_act = H_1280; v_act = V_800;  end
            RES_1440x900:  begin h_act = H_1440; v_act = V_900;  end
            RES_1600x900:  begin h_act = H_1600; v_act = V_900;  end
            RES_1680x1050: begin h_act = H_1680; v_act = V_1050; end
            RES_1920x1080: begin h_act = H_1920; v_act = V_1080; end
            default:       begin h_act = H_640;  v_act = V_480;  end
        endcase
    end

endmodule

// File: rtl/vga_interface.sv
// Colour-processor stage: splits the active area into four quadrants,
// each filled with a programmable RGB888 colour; outside the active
// area the output is black. Outputs are registered (1 clk latency).
//   clk            in   1   pixel clock, rising edge
//   rst            in   1   synchronous active-high reset
//   ch0..ch3       in   24  quadrant colours (TL, TR, BL, BR)
//   resolution     in   4   resolution code
//   px_h / px_v    in   11  current pixel column / row
//   px_12bit_data  out  12  RGB444 (upper nibbles of the selected colour)
//   px_24bit_data  out  24  RGB888 selected colour
module vga_interface
    import vga_pkg::*;
#(
    parameter int H_W = 11,
    parameter int V_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RGB888_W-1:0] ch0,
    input  logic [RGB888_W-1:0] ch1,
    input  logic [RGB888_W-1:0] ch2,
    input  logic [RGB888_W-1:0] ch3,
    input  logic [3:0]          resolution,
    input  logic [H_W-1:0]      px_h,
    input  logic [V_W-1:0]      px_v,
    output logic [RGB444_W-1:0] px_12bit_data,
    output logic [RGB888_W-1:0] px_24bit_data
);

    logic [ACT_W-1:0]    lut_h_act;
    logic [ACT_W-1:0]    lut_v_act;
    logic [H_W-1:0]      h_act;
    logic [V_W-1:0]      v_act;
    logic [H_W-1:0]      half_h;
    logic [V_W-1:0]      half_v;
    logic                right;
    logic                bottom;
    logic                blank;
    logic [RGB888_W-1:0] sel;

    vga_res_lut u_res_lut (
        .resolution (resolution),
        .h_act      (lut_h_act),
        .v_act      (lut_v_act)
    );

    assign h_act  = H_W'(lut_h_act);
    assign v_act  = V_W'(lut_v_act);
    assign half_h = h_act >> 1;
    assign half_v = v_act >> 1;

    // Column HALF_H and row HALF_V belong to the right/bottom halves.
    assign right  = (px_h >= half_h);
    assign bottom = (px_v >= half_v);
    assign blank  = (px_h >= h_act) || (px_v >= v_act);

    always_comb begin
        sel = '0;
        if (!blank) begin
            case ({bottom, right})
                2'b00:   sel = ch0;
                2'b01:   sel = ch1;
                2'b10:   sel = ch2;
                default: sel = ch3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_24bit_data <= '0;
            px_12bit_data <= '0;
        end else begin
            px_24bit_data <= sel;
            px_12bit_data <= {sel[23:20], sel[15:12], sel[7:4]};
        end
    end

endmodule

// File: tb/tb_vga_interface.sv
module tb_vga_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ch0, ch1, ch2, ch3;
    logic [3:0]  resolution;
    logic [10:0] px_h, px_v;
    logic [11:0] px_12bit_data;
    logic [23:0] px_24bit_data;

    vga_interface #(.H_W(11), .V_W(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .ch0           (ch0),
        .ch1           (ch1),
        .ch2           (ch2),
        .ch3           (ch3),
        .resolution    (resolution),
        .px_h          (px_h),
        .px_v          (px_v),
        .px_12bit_data (px_12bit_data),
        .px_24bit_data (px_24bit_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [23:0] e24;
        logic [11:0] e12;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    // staged inputs, applied at the next falling edge by step()
    logic        s_rst;
    logic [23:0] s_ch0, s_ch1, s_ch2, s_ch3;
    logic [3:0]  s_res;

    task automatic step(input int h, input int v, input logic [23:0] e24,
                        input logic [11:0] e12, input string name);
        @(negedge clk);
        rst        = s_rst;
        ch0        = s_ch0;
        ch1        = s_ch1;
        ch2        = s_ch2;
        ch3        = s_ch3;
        resolution = s_res;
        px_h       = 11'(h);
        px_v       = 11'(v);
        q.push_back('{due: cyc + 1, e24: e24, e12: e12, name: name});
    endtask

    function automatic logic [11:0] to12(input logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

    // reference quadrant selection with explicit active size
    function automatic logic [23:0] quad(input int h, input int v, input int ha, input int va,
                                         input logic [23:0] c0, input logic [23:0] c1,
                                         input logic [23:0] c2, input logic [23:0] c3);
        if (h >= ha || v >= va) return 24'h000000;
        if (v < va / 2) return (h < ha / 2) ? c0 : c1;
        return (h < ha / 2) ? c2 : c3;
    endfunction

    // monitor: outputs are sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                n_tests++;
                if (e.due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
                end else if (px_24bit_data !== e.e24 || px_12bit_data !== e.e12) begin
                    n_fail++;
                    $display("FAIL %s: got %h/%h expected %h/%h", e.name,
                             px_24bit_data, px_12bit_data, e.e24, e.e12);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] e;
        rst = 1'b1; ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
        resolution = '0; px_h = '0; px_v = '0;
        s_rst = 1'b1;
        s_ch0 = 24'hFF0000; s_ch1 = 24'h00FF00; s_ch2 = 24'h0000FF; s_ch3 = 24'hFF00FF;
        s_res = 4'b0101;

        // 1. reset with arbitrary inputs
        for (int i = 0; i < 10; i++)
            step(i * 131, i * 77, 24'h000000, 12'h000, "reset_hold");
        s_rst = 1'b0;
        step(0, 0, 24'hFF0000, 12'hF00, "reset_release");

        // 2. directed quadrant points at 1280x800
        step(639, 399,   24'hFF0000, 12'hF00, "q0_corner");
        step(640, 399,   24'h00FF00, 12'h0F0, "q1_left_edge");
        step(639, 400,   24'h0000FF, 12'h00F, "q2_top_edge");
        step(640, 400,   24'hFF00FF, 12'hF0F, "q3_corner");
        step(1279, 799,  24'hFF00FF, 12'hF0F, "last_active");
        step(1279, 0,    24'h00FF00, 12'h0F0, "last_col_top");

        // coarse sweep of 1280x800 plus the blanking margin
        for (int v = 0; v < 820; v += 20)
            for (int h = 0; h < 1300; h += 20) begin
                e = quad(h, v, 1280, 800, s_ch0, s_ch1, s_ch2, s_ch3);
                step(h, v, e, to12(e), "sweep_1280x800");
            end

        // 3. blanking
        step(1280, 0, 24'h000000, 12'h000, "blank_h");
        step(0, 800,  24'h000000, 12'h000, "blank_v");
        s_res = 4'b0000;
        step(700, 100, 24'h000000, 12'h000, "blank_640");
        step(639, 479, 24'hFF00FF, 12'hF0F, "last_active_640");

        // 4. latency: new ch0 must appear exactly one edge later
        step(0, 0, 24'hFF0000, 12'hF00, "pre_change");
        s_ch0 = 24'hA5C3E7;
        step(0, 0, 24'hA5C3E7, 12'hACE, "ch0_A5C3E7");

        // 5. fallback and 1920x1080
        s_res = 4'b1111;
        step(320, 240, 24'hFF00FF, 12'hF0F, "fallback_q3");
        step(319, 239, 24'hA5C3E7, 12'hACE, "fallback_q0");
        step(640, 0,   24'h000000, 12'h000, "fallback_blank");
        s_res = 4'b1001;
        step(960, 540, 24'hFF00FF, 12'hF0F, "r1920_q3");
        step(959, 539, 24'hA5C3E7, 12'hACE, "r1920_q0");
        step(1919, 0,  24'h00FF00, 12'h0F0, "r1920_q1_last");
        s_res = 4'b0010;
        step(512, 383, 24'h00FF00, 12'h0F0, "r1024_q1");
        step(511, 384, 24'h0000FF, 12'h00F, "r1024_q2");

        // 6. mid-sweep ch1 change in the top-right quadrant
        s_res = 4'b0101;
        step(700, 10, 24'h00FF00, 12'h0F0, "ch1_before");
        s_ch1 = 24'h123456;
        step(701, 10, 24'h123456, 12'h135, "ch1_after");

        // mid-frame reset blanks for one cycle, then colour resumes
        s_rst = 1'b1;
        step(702, 10, 24'h000000, 12'h000, "midframe_reset");
        s_rst = 1'b0;
        step(703, 10, 24'h123456, 12'h135, "after_midframe_reset");

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected samples never checked", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
